// File: rtl/section_mem_arbiter.sv
// Round-robin read arbiter sharing one tile memory among screen-section requesters.
// Define SECTION_PRIORITY_EN to favour requesters whose section the beam is currently in.
module section_mem_arbiter #(
   parameter int NREQ   = 4,
   parameter int AW     = 12,
   parameter int DW     = 8,
   parameter int RD_LAT = 2
) (
   input  logic               vga_clk,
   input  logic               rst_n,
   input  logic               arb_en,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ-1:0]    section_active,
   output logic [NREQ-1:0]    gnt,
   output logic               mem_en,
   output logic [AW-1:0]      mem_addr,
   input  logic [DW-1:0]      mem_rdata,
   output logic [NREQ-1:0]    rvalid,
   output logic [DW-1:0]      rdata
);

   localparam int LW = ($clog2(NREQ) > 3) ? $clog2(NREQ) : 3;

   logic [LW-1:0]   last;
   logic [LW-1:0]   win_idx;
   logic [NREQ-1:0] cand;
   logic            found;
   logic            grant;
   logic [NREQ-1:0] tag [RD_LAT];

`ifdef SECTION_PRIORITY_EN
   logic [NREQ-1:0] hi_class;
   logic [NREQ-1:0] lo_class;

   always_comb begin
      hi_class = req & section_active;
      lo_class = req & ~section_active;
      cand     = (|hi_class) ? hi_class : lo_class;
   end
`else
   logic section_unused;
   assign section_unused = ^section_active;

   always_comb cand = req;
`endif

   // Search starts just past the last winner and wraps modulo NREQ.
   always_comb begin
      int unsigned j;
      j       = 0;
      found   = 1'b0;
      win_idx = last;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         j = (32'(last) + k) % NREQ;
         if (!found && cand[j]) begin
            found   = 1'b1;
            win_idx = LW'(j);
         end
      end
   end

   always_comb begin
      gnt = '0;
      if (rst_n && arb_en && found) gnt[win_idx] = 1'b1;
   end

   assign grant = |gnt;

   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         last     <= LW'(NREQ - 1);
         mem_en   <= 1'b0;
         mem_addr <= '0;
      end else begin
         mem_en <= grant;
         if (grant) begin
            last     <= win_idx;
            mem_addr <= req_addr[int'(win_idx)*AW +: AW];
         end
      end
   end

   // Routing tags ride alongside the memory latency so responses return in grant order.
   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < RD_LAT; i++) tag[i] <= '0;
         rvalid <= '0;
         rdata  <= '0;
      end else begin
         tag[0] <= gnt;
         for (int unsigned i = 1; i < RD_LAT; i++) tag[i] <= tag[i-1];
         rvalid <= tag[RD_LAT-1];
         if (|tag[RD_LAT-1]) rdata <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_section_mem_arbiter.sv
// Directed self-checking bench for section_mem_arbiter (default parameters).
// Expectations for the section-priority case follow SECTION_PRIORITY_EN.
module tb_section_mem_arbiter;

   localparam int NREQ = 4;
   localparam int AW   = 12;
   localparam int DW   = 8;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               arb_en;
   logic [NREQ-1:0]    req;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ-1:0]    section_active;
   logic [NREQ-1:0]    gnt;
   logic               mem_en;
   logic [AW-1:0]      mem_addr;
   logic [DW-1:0]      mem_rdata = '0;
   logic [NREQ-1:0]    rvalid;
   logic [DW-1:0]      rdata;

   int n_chk  = 0;
   int n_pass = 0;

   section_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(2)) dut (
      .vga_clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req(req), .req_addr(req_addr),
      .section_active(section_active), .gnt(gnt), .mem_en(mem_en), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .rvalid(rvalid), .rdata(rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
      return a[7:0] ^ 8'h5A;
   endfunction

   // One-cycle synchronous RAM: data visible the cycle after mem_en.
   always @(posedge clk) if (mem_en) mem_rdata <= mem_f(mem_addr);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic set_addrs();
      for (int i = 0; i < NREQ; i++) req_addr[i*AW +: AW] = AW'(12'h100 + i);
   endtask

   // Leaves rst_n released at a negedge: the current cycle is cycle 0.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; req = '0; arb_en = 1'b0; section_active = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [NREQ-1:0] one;
      int gnt_after, rv_cnt;
      one = 4'b0001;
      rst_n = 1'b0; arb_en = 1'b1; req = 4'b1111; section_active = '0;
      req_addr = '0; set_addrs();
      #12;
      check("rst_gnt", 32'(gnt), 0);
      check("rst_mem_en", 32'(mem_en), 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_rvalid", 32'(rvalid), 0);
      check("rst_rdata", 32'(rdata), 0);

      // single read, first grant in first cycle out of reset
      do_reset();
      arb_en = 1'b1; req = 4'b0001; req_addr[0 +: AW] = 12'h0A5;
      #1 check("t1_gnt_c0", 32'(gnt), 32'h1);
      @(negedge clk); req = '0;
      #1 check("t1_mem_en_c1", 32'(mem_en), 1);
      check("t1_mem_addr_c1", 32'(mem_addr), 32'h0A5);
      check("t1_gnt_c1", 32'(gnt), 0);
      @(negedge clk); #1;
      check("t1_rvalid_c2", 32'(rvalid), 0);
      check("t1_mem_en_c2", 32'(mem_en), 0);
      @(negedge clk); #1;
      check("t1_rvalid_c3", 32'(rvalid), 32'h1);
      check("t1_rdata_c3", 32'(rdata), 32'hFF);
      @(negedge clk); #1;
      check("t1_rvalid_c4", 32'(rvalid), 0);
      check("t1_rdata_hold", 32'(rdata), 32'hFF);

      // back-to-back round robin
      set_addrs();
      do_reset();
      arb_en = 1'b1; req = 4'b1111;
      for (int c = 0; c < 11; c++) begin
         if (c == 8) req = '0;
         #1;
         check($sformatf("t2_gnt_c%0d", c), 32'(gnt), (c < 8) ? 32'(one << (c % 4)) : 0);
         check($sformatf("t2_mem_en_c%0d", c), 32'(mem_en), (c >= 1 && c <= 8) ? 1 : 0);
         if (c >= 1 && c <= 8)
            check($sformatf("t2_mem_addr_c%0d", c), 32'(mem_addr), 32'h100 + 32'((c - 1) % 4));
         check($sformatf("t2_rvalid_c%0d", c), 32'(rvalid), (c >= 3) ? 32'(one << ((c - 3) % 4)) : 0);
         if (c >= 3)
            check($sformatf("t2_rdata_c%0d", c), 32'(rdata), 32'(mem_f(AW'(12'h100 + (c - 3) % 4))));
         @(negedge clk);
      end

      // arb_en dropped after two grants, in-flight reads still return
      do_reset();
      arb_en = 1'b1; req = 4'b1111; gnt_after = 0; rv_cnt = 0;
      for (int c = 0; c < 10; c++) begin
         if (c == 2) arb_en = 1'b0;
         #1;
         if (c >= 2 && gnt != 0) gnt_after++;
         if (rvalid != 0) rv_cnt++;
         if (c == 3) check("t3_rvalid_c3", 32'(rvalid), 32'h1);
         if (c == 4) check("t3_rvalid_c4", 32'(rvalid), 32'h2);
         @(negedge clk);
      end
      check("t3_gnt_after_off", 32'(gnt_after), 0);
      check("t3_rvalid_pulses", 32'(rv_cnt), 2);

      // reset during in-flight reads
      do_reset();
      arb_en = 1'b1; req = 4'b1111;
      #1 check("t4_gnt_c0", 32'(gnt), 32'h1);
      @(negedge clk);
      #1 check("t4_gnt_c1", 32'(gnt), 32'h2);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("t4_rst_gnt", 32'(gnt), 0);
      check("t4_rst_mem_en", 32'(mem_en), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("t4_gnt_release", 32'(gnt), 32'h1);
      @(negedge clk); req = '0;
      for (int c = 1; c < 6; c++) begin
         #1 check($sformatf("t4_rvalid_r%0d", c), 32'(rvalid), (c == 3) ? 32'h1 : 0);
         @(negedge clk);
      end

      // section_active stimulus
      do_reset();
      arb_en = 1'b1; req = 4'b1111; section_active = 4'b0100;
      for (int c = 0; c < 4; c++) begin
`ifdef SECTION_PRIORITY_EN
         #1 check($sformatf("t5_gnt_c%0d", c), 32'(gnt), 32'h4);
`else
         #1 check($sformatf("t5_gnt_c%0d", c), 32'(gnt), 32'(one << c));
`endif
         @(negedge clk);
      end
      section_active = '0;
`ifdef SECTION_PRIORITY_EN
      #1 check("t5_gnt_resume", 32'(gnt), 32'h8);
`else
      #1 check("t5_gnt_resume", 32'(gnt), 32'h1);
`endif
      @(negedge clk);
      req = '0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
